shared_reg_arbiter: RTL
=======================

// Module: shared_reg_arbiter
// PURPOSE
//  Round-robin arbiter and write sequencer for one WIDTH-bit storage register built from dff cells,
//  shared by NREQ requesters. Grants one owner at a time and loads only that owner's write data.
//  A one-cycle all-idle gap on every ownership change gives break-before-make hand-over.
//  Sits between the requester blocks and the shared register bank.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  WIDTH     8   shared register width
//  MAX_HOLD  4   cycles an owner may hold the grant while another requester waits (>=1)
// PORTS
//  CLK      in   1           single clock, rising edge
//  RESET_L  in   1           asynchronous, active-low reset
//  REQ      in   NREQ        request per requester; level, held until done
//  WR       in   NREQ        write enable per requester; honoured only while granted
//  WDATA    in   NREQ*WIDTH  write data; slice i = WDATA[i*WIDTH +: WIDTH]
//  GNT      out  NREQ        one-hot grant, registered
//  OWNER    out  $clog2(NREQ)  index of current/last owner
//  BUSY     out  1           1 when state != IDLE
//  Q        out  WIDTH       shared register contents
// BEHAVIOUR
//  Reset (RESET_L=0, async, also mid-tenure): GNT=0, Q=0, BUSY=0, state=IDLE, hold count=0,
//   OWNER=NREQ-1 (requester 0 has first priority).
//  States: IDLE, OWN, TURN.
//  Pick: first i with REQ[i]=1, scanning OWNER+1, OWNER+2, ... modulo NREQ.
//  IDLE: if any REQ at an edge -> OWN; GNT=onehot(pick) and OWNER=pick from that edge (1-cycle latency).
//   Otherwise stay in IDLE.
//  OWN, owner k:
//   - Every edge with WR[k]=1 loads Q<=WDATA slice k. WR/WDATA of non-owners are ignored.
//   - Hold count increments each OWN cycle and saturates at MAX_HOLD-1.
//   - REQ[k]=0 at an edge -> TURN. A write in that same cycle is ignored because REQ[k] is low.
//   - Count==MAX_HOLD-1 and any other REQ high -> TURN (preempt). That cycle's write is still honoured.
//   - No other requester pending -> owner keeps the grant indefinitely; no preemption.
//  TURN: exactly one cycle, GNT=0, Q holds. At the next edge, pick from the current REQ -> OWN,
//   or IDLE if none. The hold count clears on entry to OWN.
//  Preempted owner keeps REQ high and re-competes; round-robin puts it last.
//  Q changes only on an owner write or reset. GNT is never more than one-hot, and two
//   different owners are never granted on adjacent cycles.
//  Priority of simultaneous events at one edge: reset > release > preempt > write-hold.
// STRUCTURE
//  Shared package arb_pkg: state encoding (IDLE=2'd0, OWN=2'd1, TURN=2'd2), onehot/index helper
//   functions, default NREQ/WIDTH/MAX_HOLD constants.
//  One sub-module: rr_pick (combinational). Inputs REQ and OWNER; outputs the pick index and a valid flag.
//  Top level holds the FSM, hold counter, OWNER register, and the Q register with its write mux.
// TESTING
//  1 Reset: drive RESET_L=0 mid-tenure (between edges) -> GNT=0 and Q=0 immediately, before any edge.
//    Release reset, REQ=0001 -> GNT=0001 after 1 edge.
//  2 Write: REQ[2]=1, WR[2]=1, slice2=8'hA5 -> GNT=0100 after edge 1; Q=8'hA5 after edge 2; BUSY=1.
//  3 Fairness: REQ=1111 held, MAX_HOLD=4 -> GNT 0001 x4, 0000 x1, 0010 x4, 0000, 0100 x4, 0000,
//    1000 x4, 0000, then 0001.
//  4 Lone owner: only REQ=0010 for 10 cycles -> GNT=0010 on all 10 cycles, with no TURN gaps.
//  5 Isolation: REQ=0011, WR=0011, slice0=8'h11, slice1=8'h22 -> Q=8'h11 during tenure 0,
//    Q=8'h22 only after GNT=0010.
//  6 Release: drop REQ[0] while owning -> GNT=0 for one cycle (TURN), then IDLE with BUSY=0;
//    Q keeps its last value.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package arb_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_t;

    // Requester index reached by stepping 'off' places past 'base', wrapping at n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

    // Bit 'pos' of the one-hot code for index 'idx'.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
        return idx == pos;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin pick: first requester after OWNER, wrapping.
// Latency: combinational. Backpressure: none, pure function of REQ and OWNER.
// Valid flag low when no request is pending.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         REQ,
    input  logic [$clog2(NREQ)-1:0] OWNER,
    output logic [$clog2(NREQ)-1:0] pick,
    output logic                    pick_vld
);

    localparam int OW = $clog2(NREQ);

    logic [OW-1:0] cand;

    // Scan farthest-first so the nearest requester after OWNER wins last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = OW'(rr_index(32'(OWNER), 32'(off), 32'(NREQ)));
            if (REQ[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration and write sequencing for one shared register.
// Latency: grant 1 cycle after request; write lands 1 cycle after owner WR; 1-cycle gap on hand-over.
// Backpressure: requesters hold REQ until granted; owner is preempted after MAX_HOLD cycles if others wait.
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                    CLK,
    input  logic                    RESET_L,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         WR,
    input  logic [NREQ*WIDTH-1:0]   WDATA,
    output logic [NREQ-1:0]         GNT,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        Q
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state;
    logic [HW-1:0] hold;
    logic [OW-1:0] pick;
    logic          pick_vld;
    logic [NREQ-1:0] pick_oh;

    logic             own_req;
    logic             own_wr;
    logic [WIDTH-1:0] own_dat;
    logic             others_wait;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .REQ      (REQ),
        .OWNER    (OWNER),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    for (genvar i = 0; i < NREQ; i++) begin : g_oh
        assign pick_oh[i] = onehot_bit(32'(pick), i);
    end

    assign own_req     = REQ[OWNER];
    assign own_wr      = WR[OWNER];
    assign own_dat     = WDATA[OWNER*WIDTH +: WIDTH];
    // GNT is the owner's one-hot while in OWN, so this masks the owner out.
    assign others_wait = |(REQ & ~GNT);
    assign BUSY        = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= S_IDLE;
            GNT   <= '0;
            OWNER <= OW'(NREQ - 1);
            hold  <= '0;
            Q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_TURN: begin
                    GNT <= '0;
                    if (pick_vld) begin
                        state <= S_OWN;
                        GNT   <= pick_oh;
                        OWNER <= pick;
                        hold  <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OWN: begin
                    if (!own_req) begin
                        state <= S_TURN;
                        GNT   <= '0;
                    end else begin
                        if (own_wr) begin
                            Q <= own_dat;
                        end
                        if (hold == HOLD_LAST && others_wait) begin
                            state <= S_TURN;
                            GNT   <= '0;
                        end else if (hold != HOLD_LAST) begin
                            hold <= hold + HW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    GNT   <= '0;
                end
            endcase
        end
    end

endmodule
